axis_width_downsizer: RTL

- Native RTL replacement for the vendor 64-to-8 AXI-stream width converter on the path from the AWS host to the zcash core.
- Accepts wide `if_axi_stream` words (IN_BYTS lanes) and serialises them into narrow words (OUT_BYTS lanes).
- Carries mod, eop and err through, and regenerates sop internally.
- Sits between the AWS shell stream and the zcash byte-oriented core.

---
 rtl/axis_width_pkg.sv | 20 ++
 rtl/axis_width_downsizer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/axis_width_pkg.sv
// Shared types and helpers for the AXI-stream width converters.
// Used by both the downsizer and the companion upsizer.
package axis_width_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } dsz_state_t;

    // Ceiling division: number of narrow beats needed for nb valid bytes.
    function automatic int unsigned beats(input int unsigned nb, input int unsigned out_byts);
        return (nb + out_byts - 1) / out_byts;
    endfunction

    // Width of a mod/index field for n lanes, never narrower than one bit.
    function automatic int unsigned mod_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_width_downsizer.sv
// Serialises wide AXI-stream words into narrow beats, lane 0 first.
// Carries mod/eop/err/ctl through and regenerates sop on the narrow side.
module axis_width_downsizer
    import axis_width_pkg::*;
#(
    parameter int unsigned IN_BYTS  = 8,
    parameter int unsigned OUT_BYTS = 1,
    parameter int unsigned CTL_BITS = 8,
    localparam int unsigned IN_MOD_W  = mod_width(IN_BYTS),
    localparam int unsigned OUT_MOD_W = mod_width(OUT_BYTS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_axi_val,
    output logic                  i_axi_rdy,
    input  logic [IN_BYTS*8-1:0]  i_axi_dat,
    input  logic [IN_MOD_W-1:0]   i_axi_mod,
    input  logic                  i_axi_eop,
    input  logic                  i_axi_err,
    input  logic [CTL_BITS-1:0]   i_axi_ctl,
    output logic                  o_axi_val,
    input  logic                  o_axi_rdy,
    output logic [OUT_BYTS*8-1:0] o_axi_dat,
    output logic [OUT_MOD_W-1:0]  o_axi_mod,
    output logic                  o_axi_sop,
    output logic                  o_axi_eop,
    output logic                  o_axi_err,
    output logic [CTL_BITS-1:0]   o_axi_ctl
);

    localparam int unsigned RATIO = IN_BYTS / OUT_BYTS;
    localparam int unsigned IDX_W = mod_width(RATIO);
    localparam int unsigned IN_W  = IN_BYTS * 8;
    localparam int unsigned OUT_W = OUT_BYTS * 8;

    if (IN_BYTS % OUT_BYTS != 0) begin : g_bad_ratio
        $fatal(1, "axis_width_downsizer: IN_BYTS must be a multiple of OUT_BYTS");
    end

    dsz_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      last_q;
    logic [IN_W-1:0]       dat_q;
    logic [OUT_MOD_W-1:0]  omod_q;
    logic                  eop_q, err_q, sop_q, sop_d;
    logic [CTL_BITS-1:0]   ctl_q;

    int unsigned           in_nb;
    logic [IN_W-1:0]       in_dat;
    logic [IDX_W-1:0]      in_last;
    logic [OUT_MOD_W-1:0]  in_omod;
    logic                  last, beat_acc, load;

    // Precompute the beat count and tail mod of the incoming word so DRAIN only compares idx.
    always_comb begin
        in_nb  = (i_axi_eop && i_axi_mod != '0) ? 32'(i_axi_mod) : IN_BYTS;
        in_dat = '0;
        for (int unsigned b = 0; b < IN_BYTS; b++) begin
            if (b < in_nb) in_dat[b*8 +: 8] = i_axi_dat[b*8 +: 8];
        end
        in_last = IDX_W'(beats(in_nb, OUT_BYTS) - 1);
        in_omod = OUT_MOD_W'(in_nb % OUT_BYTS);
    end

    assign last      = (idx_q == last_q);
    assign beat_acc  = (state_q == DRAIN) && o_axi_rdy;
    // Ready passes o_axi_rdy through on the last beat so words follow without a bubble.
    assign i_axi_rdy = i_rst_n && ((state_q == EMPTY) || (last && o_axi_rdy));
    assign load      = i_axi_val && i_axi_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            last_q  <= '0;
            dat_q   <= '0;
            omod_q  <= '0;
            eop_q   <= 1'b0;
            err_q   <= 1'b0;
            ctl_q   <= '0;
            sop_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sop_q   <= sop_d;
            if (load) begin
                last_q <= in_last;
                dat_q  <= in_dat;
                omod_q <= in_omod;
                eop_q  <= i_axi_eop;
                err_q  <= i_axi_err;
                ctl_q  <= i_axi_ctl;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sop_d   = sop_q;
        if (beat_acc) begin
            sop_d = eop_q && last;
            if (!last) begin
                idx_d = idx_q + 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end
        if (load) begin
            state_d = DRAIN;
            idx_d   = '0;
        end
    end

    always_comb begin
        o_axi_val = (state_q == DRAIN);
        o_axi_dat = '0;
        for (int unsigned r = 0; r < RATIO; r++) begin
            if (idx_q == IDX_W'(r)) o_axi_dat = dat_q[r*OUT_W +: OUT_W];
        end
        o_axi_eop = eop_q && last;
        o_axi_err = err_q && last;
        o_axi_mod = o_axi_eop ? omod_q : '0;
        o_axi_ctl = ctl_q;
        o_axi_sop = sop_q;
    end

endmodule
